vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised VGA raster timing generator producing horizontal and vertical sync, display-enable and pixel coordinates from a single clock with a pixel-rate enable. It replaces the horizontal-only FSM plus external counter pair. Porch, sync and active widths for both axes, and sync polarity, are set by parameters. It sits between the clock/enable generator and the pixel/framebuffer fetch logic.

## Interface

**Parameters**

- `H_DISP`, 640: active pixels per line.
- `H_FP`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: horizontal sync width, in pixels.
- `H_BP`, 48: horizontal back porch, in pixels.
- `V_DISP`, 480: active lines per frame.
- `V_FP`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vertical sync width, in lines.
- `V_BP`, 33: vertical back porch, in lines.
- `H_POL`, 0: `hs_o` active level (0 = active-low).
- `V_POL`, 0: `vs_o` active level (0 = active-low).
- `CNT_W`, 10: width of the `x_o` and `y_o` counters.

**Ports**

- `clk_i`, in, 1: clock. One clock only.
- `rst_ni`, in, 1: reset. Synchronous, active-low.
- `str_i`, in, 1: start / keep running.
- `pix_en_i`, in, 1: pixel tick. Counters advance only on cycles where this is 1.
- `busy_o`, out, 1: generator is running (not in IDLE).
- `hs_o`, out, 1: horizontal sync, at level `H_POL` while active.
- `vs_o`, out, 1: vertical sync, at level `V_POL` while active.
- `dsp_o`, out, 1: pixel at (`x_o`, `y_o`) is in the visible area.
- `x_o`, out, CNT_W: current column.
- `y_o`, out, CNT_W: current line.
- `line_o`, `frame_o`, out, 1 each: present only with `VGA_TIMING_PULSE_EN`.

## Operation

- Derived totals: `H_TOTAL = H_DISP+H_FP+H_SYNC+H_BP` (800). `V_TOTAL = V_DISP+V_FP+V_SYNC+V_BP` (525).
- Each axis FSM has states S_IDLE, S_DISP, S_FP, S_SYNC, S_BP. The state is decoded from its counter:
  - S_DISP: `cnt < DISP`.
  - S_FP: `DISP ≤ cnt < DISP+FP`.
  - S_SYNC: `DISP+FP ≤ cnt < DISP+FP+SYNC`.
  - S_BP: the remainder.
- S_IDLE:
  - `x = y = 0`.
  - `busy_o = 0`, `dsp_o = 0`, syncs inactive.
  - Leaves S_IDLE on any cycle with `str_i = 1`, independent of `pix_en_i`.
- While running:
  - On `pix_en_i`, `x` increments. At `x = H_TOTAL-1`, `x` wraps to 0 and `y` increments.
  - At `y = V_TOTAL-1` with the `x` wrap, `y` wraps to 0.
- `dsp_o = (x < H_DISP) && (y < V_DISP)`.
- `hs_o` is active while `x` is in S_SYNC. `vs_o` is active while `y` is in S_SYNC, for whole lines.
- `str_i` is sampled only at the end of a frame (the `x` and `y` double wrap):
  - `str_i = 1`: continue at (0, 0).
  - `str_i = 0`: return to S_IDLE.
  - Deasserting `str_i` mid-frame never truncates the frame.
- Arithmetic: counters are unsigned CNT_W bits. Elaboration `$error` if `H_TOTAL-1` or `V_TOTAL-1` exceeds `2**CNT_W - 1`, or if any width parameter is 0.

## Timing

- **Reset** (`rst_ni = 0` at the clock edge), values next cycle:
  - `busy_o = 0`, `dsp_o = 0`, `x_o = 0`, `y_o = 0`.
  - `hs_o = ~H_POL`, `vs_o = ~V_POL`.
  - `line_o = 0`, `frame_o = 0`.
- Reset mid-frame aborts immediately. Reset has priority over `str_i` and `pix_en_i`.
- **Start latency:** `str_i` is high at edge N. At N+1, `busy_o = 1`, `dsp_o = 1`, and `x = y = 0`.
- All outputs are registered and mutually consistent: the sync, display and pulse outputs always describe the `x_o`/`y_o` shown in the same cycle. There is no combinational path from inputs to outputs.
- **`pix_en_i = 0`:** every output holds.
- **Period:** line = H_TOTAL enabled cycles; frame = H_TOTAL·V_TOTAL enabled cycles.
- **Simultaneous events:** `str_i = 0` at the end-of-frame wrap leaves `x = y = 0` with `busy_o = 0` at the next cycle.

## Configuration

- Macro: `VGA_TIMING_PULSE_EN`.
- **Defined:**
  - `line_o` is a one-cycle pulse on the cycle `x_o` becomes 0, on every line including the start.
  - `frame_o` is a one-cycle pulse when (`x_o`, `y_o`) becomes (0, 0), on every frame including the start.
  - A pulse coincides with the first cycle at that position and does not stretch while `pix_en_i = 0`.
- **Undefined:** neither port exists, and there is no pulse logic.

## Structure

- Package `vga_pkg` holds:
  - `typedef enum logic [2:0] axis_state_t {S_IDLE, S_DISP, S_FP, S_SYNC, S_BP}`.
  - Localparams for the 640x480@60 default timings.
- Sub-module `vga_axis_fsm` (parameters DISP/FP/SYNC/BP/POL/CNT_W):
  - Inputs: `run`, `adv`.
  - Outputs: counter, state, `sync`, `wrap`.
- `vga_timing_gen` instantiates `vga_axis_fsm` twice. The horizontal instance's `wrap` drives the vertical instance's `adv`.

## Test plan

- **Reset:** `rst_ni = 0` for 2 cycles with `str_i = 1` → all outputs at their reset values. `str_i` held, `rst_ni` released → `busy_o = 1`, `dsp_o = 1`, `x = y = 0` one cycle later.
- **Default line** (`pix_en_i` constant 1):
  - `dsp_o` high for x 0..639.
  - `hs_o` low exactly for x 656..751.
  - `x` wraps after 799, `y` goes from 0 to 1.
- **Frame:**
  - `vs_o` low exactly for y 490..491.
  - `dsp_o` never high for y ≥ 480.
  - The frame is 420000 cycles, then (0, 0) again.
- **`pix_en_i` every 4th cycle:** outputs hold between ticks. The line takes 3200 cycles. `frame_o`/`line_o` (macro defined) pulse exactly 1 cycle.
- **Stop and abort:**
  - `str_i` dropped at y = 100 → the frame completes to y = 524, then `busy_o = 0`.
  - `rst_ni` pulsed at x = 300 → next cycle the generator is in S_IDLE with `x = 0`.
- **Small timing:** H = 4/1/2/1, V = 2/1/1/1, `H_POL = V_POL = 1`, `CNT_W = 3` → `hs_o` high at x 5..6, `vs_o` high on y = 3, 40-cycle frame.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types and 640x480@60 default timings for the VGA raster generator.
package vga_pkg;

  typedef enum logic [2:0] {S_IDLE, S_DISP, S_FP, S_SYNC, S_BP} axis_state_t;

  localparam int VGA_H_DISP = 640;
  localparam int VGA_H_FP   = 16;
  localparam int VGA_H_SYNC = 96;
  localparam int VGA_H_BP   = 48;
  localparam int VGA_V_DISP = 480;
  localparam int VGA_V_FP   = 10;
  localparam int VGA_V_SYNC = 2;
  localparam int VGA_V_BP   = 33;
  localparam int VGA_CNT_W  = 10;

  // Region of an axis counter; BP is whatever lies past sync.
  function automatic axis_state_t axis_decode(input int c, input int disp,
                                              input int fp, input int sync);
    if (c < disp)                 return S_DISP;
    else if (c < disp + fp)        return S_FP;
    else if (c < disp + fp + sync) return S_SYNC;
    return S_BP;
  endfunction

endpackage

// File: rtl/vga_axis_fsm.sv
// One raster axis: counter, region state and sync level, all registered.
module vga_axis_fsm import vga_pkg::*; #(
  parameter int DISP  = VGA_H_DISP,
  parameter int FP    = VGA_H_FP,
  parameter int SYNC  = VGA_H_SYNC,
  parameter int BP    = VGA_H_BP,
  parameter bit POL   = 1'b0,
  parameter int CNT_W = VGA_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             adv,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_nxt,
  output axis_state_t      state,
  output logic             sync,
  output logic             wrap
);

  localparam int TOTAL = DISP + FP + SYNC + BP;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

  if (DISP == 0 || FP == 0 || SYNC == 0 || BP == 0) begin : g_zero_chk
    $error("vga_axis_fsm: every timing width must be non-zero");
  end
  if (TOTAL - 1 > (2 ** CNT_W) - 1) begin : g_cnt_chk
    $error("vga_axis_fsm: period does not fit in CNT_W bits");
  end

  axis_state_t state_nxt;

  // wrap must not depend on run: the top derives run from it.
  assign wrap = adv && (state != S_IDLE) && (cnt == LAST);

  always_comb begin
    cnt_nxt = cnt;
    if (!run || state == S_IDLE) cnt_nxt = '0;
    else if (adv)                cnt_nxt = (cnt == LAST) ? '0 : cnt + CNT_W'(1);
    state_nxt = run ? axis_decode(int'(cnt_nxt), DISP, FP, SYNC) : S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= '0;
      state <= S_IDLE;
      sync  <= ~POL;
    end else begin
      cnt   <= cnt_nxt;
      state <= state_nxt;
      sync  <= (state_nxt == S_SYNC) ? POL : ~POL;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator; line_o/frame_o pulses exist only when
// VGA_TIMING_PULSE_EN is defined.
module vga_timing_gen import vga_pkg::*; #(
  parameter int H_DISP = VGA_H_DISP,
  parameter int H_FP   = VGA_H_FP,
  parameter int H_SYNC = VGA_H_SYNC,
  parameter int H_BP   = VGA_H_BP,
  parameter int V_DISP = VGA_V_DISP,
  parameter int V_FP   = VGA_V_FP,
  parameter int V_SYNC = VGA_V_SYNC,
  parameter int V_BP   = VGA_V_BP,
  parameter bit H_POL  = 1'b0,
  parameter bit V_POL  = 1'b0,
  parameter int CNT_W  = VGA_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             str_i,
  input  logic             pix_en_i,
  output logic             busy_o,
  output logic             hs_o,
  output logic             vs_o,
  output logic             dsp_o,
  output logic [CNT_W-1:0] x_o,
  output logic [CNT_W-1:0] y_o
`ifdef VGA_TIMING_PULSE_EN
  ,
  output logic             line_o,
  output logic             frame_o
`endif
);

  logic             run, h_wrap, v_wrap, frame_end;
  logic [CNT_W-1:0] h_nxt, v_nxt;
  axis_state_t      h_state, v_state;

  assign frame_end = h_wrap && v_wrap;
  // str_i only matters when idle or at the end-of-frame double wrap.
  assign run = busy_o ? !(frame_end && !str_i) : str_i;

  vga_axis_fsm #(.DISP(H_DISP), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP),
                 .POL(H_POL), .CNT_W(CNT_W)) u_h (
    .clk(clk_i), .rst_n(rst_ni), .run(run), .adv(pix_en_i),
    .cnt(x_o), .cnt_nxt(h_nxt), .state(h_state), .sync(hs_o), .wrap(h_wrap)
  );

  vga_axis_fsm #(.DISP(V_DISP), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP),
                 .POL(V_POL), .CNT_W(CNT_W)) u_v (
    .clk(clk_i), .rst_n(rst_ni), .run(run), .adv(h_wrap),
    .cnt(y_o), .cnt_nxt(v_nxt), .state(v_state), .sync(vs_o), .wrap(v_wrap)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      busy_o <= 1'b0;
      dsp_o  <= 1'b0;
    end else begin
      busy_o <= run;
      dsp_o  <= run && (h_nxt < CNT_W'(H_DISP)) && (v_nxt < CNT_W'(V_DISP));
    end
  end

`ifdef VGA_TIMING_PULSE_EN
  // Pulses fire on the cycle the position becomes zero, including the start.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      line_o  <= 1'b0;
      frame_o <= 1'b0;
    end else begin
      line_o  <= run && (!busy_o || h_wrap);
      frame_o <= run && (!busy_o || frame_end);
    end
  end
`endif

  a_axes_idle_together: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (h_state == S_IDLE) == (v_state == S_IDLE));

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

`ifdef VGA_TIMING_PULSE_EN
  localparam bit PULSE = 1'b1;
`else
  localparam bit PULSE = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0, str = 1'b0, pe = 1'b0;
  always #5 clk = ~clk;

  logic       a_busy, a_hs, a_vs, a_dsp, a_ln, a_fr;
  logic [9:0] a_x, a_y;
  logic       b_busy, b_hs, b_vs, b_dsp, b_ln, b_fr;
  logic [2:0] b_x, b_y;

  vga_timing_gen u_a (
    .clk_i(clk), .rst_ni(rst_n), .str_i(str), .pix_en_i(pe),
    .busy_o(a_busy), .hs_o(a_hs), .vs_o(a_vs), .dsp_o(a_dsp),
    .x_o(a_x), .y_o(a_y)
`ifdef VGA_TIMING_PULSE_EN
    , .line_o(a_ln), .frame_o(a_fr)
`endif
  );

  vga_timing_gen #(.H_DISP(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                   .V_DISP(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
                   .H_POL(1'b1), .V_POL(1'b1), .CNT_W(3)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .str_i(str), .pix_en_i(pe),
    .busy_o(b_busy), .hs_o(b_hs), .vs_o(b_vs), .dsp_o(b_dsp),
    .x_o(b_x), .y_o(b_y)
`ifdef VGA_TIMING_PULSE_EN
    , .line_o(b_ln), .frame_o(b_fr)
`endif
  );

`ifndef VGA_TIMING_PULSE_EN
  assign a_ln = 1'b0;
  assign a_fr = 1'b0;
  assign b_ln = 1'b0;
  assign b_fr = 1'b0;
`endif

  typedef struct {
    string name;
    bit    sel;
    int    x, y;
    bit    busy, hs, vs, dsp, ln, fr, chk_p;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0, n_fail = 0;
  bit   finished = 1'b0;

  int hd[2]  = '{640, 4};
  int hf[2]  = '{16, 1};
  int hsw[2] = '{96, 2};
  int hb[2]  = '{48, 1};
  int vd[2]  = '{480, 2};
  int vf[2]  = '{10, 1};
  int vsw[2] = '{2, 1};
  int vb[2]  = '{33, 1};
  bit pol[2] = '{1'b0, 1'b1};
  int mx[2], my[2];
  bit mb[2], mln[2], mfr[2];

  task automatic summary();
    if (!finished) begin
      finished = 1'b1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    end
  endtask

  task automatic model_step(input int s, input bit r, input bit st, input bit p);
    int ht, vt;
    ht = hd[s] + hf[s] + hsw[s] + hb[s];
    vt = vd[s] + vf[s] + vsw[s] + vb[s];
    mln[s] = 1'b0;
    mfr[s] = 1'b0;
    if (!r) begin
      mb[s] = 1'b0; mx[s] = 0; my[s] = 0;
    end else if (!mb[s]) begin
      if (st) begin mb[s] = 1'b1; mx[s] = 0; my[s] = 0; mln[s] = 1'b1; mfr[s] = 1'b1; end
    end else if (p) begin
      if (mx[s] == ht - 1) begin
        mx[s] = 0;
        if (my[s] == vt - 1) begin
          my[s] = 0;
          if (st) begin mln[s] = 1'b1; mfr[s] = 1'b1; end
          else mb[s] = 1'b0;
        end else begin
          my[s] = my[s] + 1;
          mln[s] = 1'b1;
        end
      end else mx[s] = mx[s] + 1;
    end
  endtask

  task automatic push_model(input int s);
    exp_t e;
    bit   hin, vin;
    hin = mx[s] >= hd[s] + hf[s] && mx[s] < hd[s] + hf[s] + hsw[s];
    vin = my[s] >= vd[s] + vf[s] && my[s] < vd[s] + vf[s] + vsw[s];
    e.name  = (s == 1) ? "small_model" : "dflt_model";
    e.sel   = (s == 1);
    e.x     = mx[s];
    e.y     = my[s];
    e.busy  = mb[s];
    e.hs    = (mb[s] && hin) ? pol[s] : !pol[s];
    e.vs    = (mb[s] && vin) ? pol[s] : !pol[s];
    e.dsp   = mb[s] && mx[s] < hd[s] && my[s] < vd[s];
    e.ln    = mln[s];
    e.fr    = mfr[s];
    e.chk_p = PULSE;
    q.push_back(e);
  endtask

  task automatic push_const(input string nm, input bit s, input int x, input int y,
                            input bit busy, input bit hs, input bit vs, input bit dsp,
                            input bit ln, input bit fr);
    exp_t e;
    e.name = nm; e.sel = s; e.x = x; e.y = y;
    e.busy = busy; e.hs = hs; e.vs = vs; e.dsp = dsp;
    e.ln = ln; e.fr = fr; e.chk_p = PULSE;
    q.push_back(e);
  endtask

  task automatic tick(input bit r, input bit st, input bit p);
    rst_n = r; str = st; pe = p;
    @(posedge clk);
    model_step(0, r, st, p);
    model_step(1, r, st, p);
    #1;
    push_model(0);
    push_model(1);
  endtask

  exp_t me;
  int   ax, ay;
  logic ab, ahs, avs, adsp, aln, afr;

  always @(negedge clk) begin
    while (q.size() > 0) begin
      me = q.pop_front();
      if (me.sel) begin
        ax = int'(b_x); ay = int'(b_y); ab = b_busy; ahs = b_hs; avs = b_vs;
        adsp = b_dsp; aln = b_ln; afr = b_fr;
      end else begin
        ax = int'(a_x); ay = int'(a_y); ab = a_busy; ahs = a_hs; avs = a_vs;
        adsp = a_dsp; aln = a_ln; afr = a_fr;
      end
      n_chk++;
      if (ax != me.x || ay != me.y || ab !== me.busy || ahs !== me.hs ||
          avs !== me.vs || adsp !== me.dsp ||
          (me.chk_p && (aln !== me.ln || afr !== me.fr))) begin
        n_fail++;
        $display("FAIL %s @%0t: got x=%0d y=%0d busy=%b hs=%b vs=%b dsp=%b line=%b frame=%b, expected x=%0d y=%0d busy=%b hs=%b vs=%b dsp=%b line=%b frame=%b",
                 me.name, $time, ax, ay, ab, ahs, avs, adsp, aln, afr,
                 me.x, me.y, me.busy, me.hs, me.vs, me.dsp, me.ln, me.fr);
      end
    end
    if (n_fail >= 30) begin
      summary();
      $finish;
    end
  end

  initial begin
    #200000;
    if (!finished) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout @%0t: test sequence did not complete", $time);
      summary();
      $finish;
    end
  end

  initial begin
    tick(0, 1, 1);
    tick(0, 1, 1);
    n_chk++;
    if (a_busy !== 1'b0 || a_dsp !== 1'b0 || a_x !== '0 || a_y !== '0 ||
        a_hs !== 1'b1 || a_vs !== 1'b1 ||
        b_busy !== 1'b0 || b_dsp !== 1'b0 || b_x !== '0 || b_y !== '0 ||
        b_hs !== 1'b0 || b_vs !== 1'b0 ||
        (PULSE && (a_ln !== 1'b0 || a_fr !== 1'b0 || b_ln !== 1'b0 || b_fr !== 1'b0))) begin
      n_fail++;
      $display("FAIL rst_direct @%0t: a busy=%b dsp=%b x=%0d y=%0d hs=%b vs=%b, b busy=%b dsp=%b x=%0d y=%0d hs=%b vs=%b",
               $time, a_busy, a_dsp, a_x, a_y, a_hs, a_vs,
               b_busy, b_dsp, b_x, b_y, b_hs, b_vs);
    end
    push_const("rst_dflt",  0, 0, 0, 0, 1, 1, 0, 0, 0);
    push_const("rst_small", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(1, 1, 1);
    push_const("start_dflt", 0, 0, 0, 1, 1, 1, 1, 1, 1);

    for (int t = 1; t <= 800; t++) begin
      tick(1, 1, 1);
      case (t)
        29:  push_const("small_sync",  1, 5, 3, 1, 1, 1, 0, 0, 0);
        40:  push_const("small_frame", 1, 0, 0, 1, 0, 0, 1, 1, 1);
        639: push_const("dsp_last",    0, 639, 0, 1, 1, 1, 1, 0, 0);
        640: push_const("dsp_off",     0, 640, 0, 1, 1, 1, 0, 0, 0);
        655: push_const("hs_pre",      0, 655, 0, 1, 1, 1, 0, 0, 0);
        656: push_const("hs_first",    0, 656, 0, 1, 0, 1, 0, 0, 0);
        751: push_const("hs_last",     0, 751, 0, 1, 0, 1, 0, 0, 0);
        752: push_const("hs_post",     0, 752, 0, 1, 1, 1, 0, 0, 0);
        799: push_const("line_end",    0, 799, 0, 1, 1, 1, 0, 0, 0);
        800: push_const("line_wrap",   0, 0, 1, 1, 1, 1, 1, 1, 0);
        default: ;
      endcase
    end

    tick(0, 1, 0);
    tick(1, 1, 0);
    push_const("start_noen", 0, 0, 0, 1, 1, 1, 1, 1, 1);
    for (int i = 0; i < 3200; i++) begin
      tick(1, 1, (i % 4) == 3);
      case (i)
        1:    push_const("pulse_1cyc", 0, 0, 0, 1, 1, 1, 1, 0, 0);
        3:    push_const("slow_adv",   0, 1, 0, 1, 1, 1, 1, 0, 0);
        3196: push_const("slow_hold",  0, 799, 0, 1, 1, 1, 0, 0, 0);
        3199: push_const("slow_wrap",  0, 0, 1, 1, 1, 1, 1, 1, 0);
        default: ;
      endcase
    end

    tick(0, 1, 1);
    tick(1, 1, 1);
    for (int m = 1; m <= 39; m++) begin
      tick(1, m <= 8, 1);
      if (m == 39) push_const("stop_last", 1, 7, 4, 1, 0, 0, 0, 0, 0);
    end
    tick(1, 0, 1);
    push_const("stop_idle", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(1, 0, 1);
    tick(1, 0, 1);
    push_const("stay_idle", 1, 0, 0, 0, 0, 0, 0, 0, 0);

    tick(0, 1, 1);
    tick(1, 1, 1);
    for (int k = 1; k <= 300; k++) begin
      tick(1, 1, 1);
      if (k == 300) push_const("pre_abort", 0, 300, 0, 1, 1, 1, 1, 0, 0);
    end
    tick(0, 1, 1);
    push_const("abort", 0, 0, 0, 0, 1, 1, 0, 0, 0);
    tick(1, 0, 1);
    push_const("abort_idle", 0, 0, 0, 0, 1, 1, 0, 0, 0);
    tick(1, 1, 1);
    push_const("restart", 0, 0, 0, 1, 1, 1, 1, 1, 1);
    tick(1, 1, 1);

    repeat (2) @(posedge clk);
    summary();
    $finish;
  end

endmodule
